bitrev_reorder: RTL

- Output-side reorder buffer for the streaming SDF FFT pipeline.
- The butterfly/delay stages emit each N-point frame in bit-reversed index order. This block writes each frame into a ping-pong complex RAM at bit-reversed addresses and reads it back in natural order.
- Sits after the last FFT stage and feeds downstream magnitude/readout logic.
- Writes may be gapped; readout of each frame is a contiguous N-cycle burst.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/cplx_sdp_ram.sv | 45 ++++
 rtl/bitrev_reorder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the streaming SDF FFT datapath.
//   FFT_DATA_W / FFT_N_LOG2 : default component width and log2 transform length
//   cplx_t                  : packed complex sample {re, im}
//   bitrev()                : reverses the low nbits of an index (nbits <= 16)
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_DATA_W   = 16;
    localparam int FFT_N_LOG2   = 4;
    localparam int BITREV_MAX_W = 16;
    localparam int BITREV_IDX_W = 4;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

    // Bits at and above nbits are returned as zero; callers size-cast the
    // result down to their own index width.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] idx,
        input int                      nbits
    );
        logic [BITREV_MAX_W-1:0] r;
        logic [BITREV_IDX_W-1:0] src;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < nbits) begin
                src                   = BITREV_IDX_W'(nbits - 1 - i);
                r[BITREV_IDX_W'(i)]   = idx[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_sdp_ram.sv
// -----------------------------------------------------------------------------
// cplx_sdp_ram
// Simple dual-port complex sample RAM, depth 2N (two banks of N), registered
// read. The bank select is the address MSB.
//   clk   : clock
//   rst   : synchronous active-high, clears the read register only
//   we    : write enable, waddr / wdata : write address / {re, im}
//   re    : read enable,  raddr         : read address
//   rdata : registered read data {re, im}; holds while re=0
// -----------------------------------------------------------------------------
module cplx_sdp_ram #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [N_LOG2:0]     waddr,
    input  logic [2*DATA_W-1:0] wdata,
    input  logic                re,
    input  logic [N_LOG2:0]     raddr,
    output logic [2*DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 << N_LOG2;

    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the block's output register, so it carries the
    // reset-to-zero and hold-when-idle behaviour of the sample outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bitrev_reorder.sv
// -----------------------------------------------------------------------------
// bitrev_reorder
// Output reorder buffer for the SDF FFT: frames arrive in bit-reversed index
// order (possibly gapped), are written to a ping-pong RAM at bit-reversed
// addresses and read back as contiguous natural-order N-cycle bursts.
//   clk, rst            : clock, synchronous active-high reset
//   enable, in_first    : input sample valid, first-of-frame marker
//   x_in_re / x_in_im   : signed input sample
//   x_out_re / x_out_im : signed natural-order output sample (held when idle)
//   out_valid/out_first : output valid, natural index 0 marker
//   frame_err           : sticky, a frame restarted before completion
// -----------------------------------------------------------------------------
module bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_first,
    input  logic signed [DATA_W-1:0] x_in_re,
    input  logic signed [DATA_W-1:0] x_in_im,
    output logic signed [DATA_W-1:0] x_out_re,
    output logic signed [DATA_W-1:0] x_out_im,
    output logic                     out_valid,
    output logic                     out_first,
    output logic                     frame_err
);

    localparam logic [N_LOG2-1:0] LAST = N_LOG2'((1 << N_LOG2) - 1);

    typedef enum logic { RD_IDLE, RD_READ } rd_state_t;

    // Writer
    logic              synced_q;
    logic [N_LOG2-1:0] wcnt_q;
    logic              wbank_q;
    logic              frame_err_q;
    logic              wr_en;
    logic              wr_done;
    logic [N_LOG2-1:0] widx;
    logic [N_LOG2:0]   waddr;

    always_comb begin
        wr_en   = enable && (in_first || synced_q);
        widx    = in_first ? '0 : wcnt_q;
        wr_done = enable && synced_q && !in_first && (wcnt_q == LAST);
        waddr   = {wbank_q, N_LOG2'(bitrev(BITREV_MAX_W'(widx), N_LOG2))};
    end

    // After a completed frame the writer drops back to unsynced, so the next
    // frame is only accepted once it opens with in_first.
    always_ff @(posedge clk) begin
        if (rst) begin
            synced_q    <= 1'b0;
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (enable) begin
            if (in_first) begin
                if (synced_q && (wcnt_q != '0)) begin
                    frame_err_q <= 1'b1;
                end
                synced_q <= 1'b1;
                wcnt_q   <= N_LOG2'(1);
            end else if (synced_q) begin
                if (wcnt_q == LAST) begin
                    wcnt_q   <= '0;
                    wbank_q  <= ~wbank_q;
                    synced_q <= 1'b0;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
        end
    end

    // Reader
    rd_state_t         state_q, state_n;
    logic [N_LOG2-1:0] raddr_q, raddr_n;
    logic              rbank_q, rbank_n;
    logic              pending_q, pending_n;
    logic              pbank_q, pbank_n;
    logic              direct_take;

    always_comb begin
        state_n     = state_q;
        raddr_n     = raddr_q;
        rbank_n     = rbank_q;
        pending_n   = pending_q;
        pbank_n     = pbank_q;
        direct_take = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (pending_q) begin
                    state_n   = RD_READ;
                    raddr_n   = '0;
                    rbank_n   = pbank_q;
                    pending_n = 1'b0;
                end
            end
            RD_READ: begin
                raddr_n = raddr_q + 1'b1;
                if (raddr_q == LAST) begin
                    raddr_n = '0;
                    if (pending_q) begin
                        rbank_n   = pbank_q;
                        pending_n = 1'b0;
                    end else if (wr_done) begin
                        // Bank completing on our last address: hand over
                        // directly without passing through pending.
                        rbank_n     = wbank_q;
                        direct_take = 1'b1;
                    end else begin
                        state_n = RD_IDLE;
                    end
                end
            end
            default: state_n = RD_IDLE;
        endcase

        if (wr_done && !direct_take) begin
            pending_n = 1'b1;
            pbank_n   = wbank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            raddr_q   <= '0;
            rbank_q   <= 1'b0;
            pending_q <= 1'b0;
            pbank_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            raddr_q   <= raddr_n;
            rbank_q   <= rbank_n;
            pending_q <= pending_n;
            pbank_q   <= pbank_n;
        end
    end

    // Input rate <= 1/cycle means a second completion cannot arrive before
    // the first one is picked up.
    assert property (@(posedge clk) disable iff (rst) !(wr_done && pending_q));

    // ---- stage p0 -> p1: RAM read, valid/first travel with the read data ----
    logic                rd_vld_p1;
    logic                rd_first_p1;
    logic [2*DATA_W-1:0] rdata_p1;

    cplx_sdp_ram #(
        .N_LOG2 (N_LOG2),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (waddr),
        .wdata ({x_in_re, x_in_im}),
        .re    (state_q == RD_READ),
        .raddr ({rbank_q, raddr_q}),
        .rdata (rdata_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1   <= 1'b0;
            rd_first_p1 <= 1'b0;
        end else begin
            rd_vld_p1   <= (state_q == RD_READ);
            rd_first_p1 <= (state_q == RD_READ) && (raddr_q == '0);
        end
    end

    assign x_out_re  = rdata_p1[2*DATA_W-1:DATA_W];
    assign x_out_im  = rdata_p1[DATA_W-1:0];
    assign out_valid = rd_vld_p1;
    assign out_first = rd_first_p1;
    assign frame_err = frame_err_q;

endmodule
